mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while the instruction side waits.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 I_READ  in  1  instruction-fetch request; I_ADDRESS  in  32  fetch address.
REQ-005 I_READDATA  out  32  fetched word; I_BUSYWAIT  out  1  fetch stall.
REQ-006 D_READ, D_WRITE  in  1 each  data request; D_ADDRESS  in  32; D_WRITEDATA  in  32; D_FUNC3  in  3  access size/sign.
REQ-007 D_READDATA  out  32  load result; D_BUSYWAIT  out  1  data stall.
REQ-008 M_READ, M_WRITE  out  1 each; M_ADDRESS  out  32; M_WRITEDATA  out  32; M_FUNC3  out  3  shared memory port.
REQ-009 M_READDATA  in  32; M_BUSYWAIT  in  1  high while the memory services an asserted M_READ/M_WRITE.

Function
REQ-010 FSM states SHALL be IDLE, GRANT, RELEASE; owner register SHALL record I or D.
REQ-011 IDLE: any pending request -> GRANT next edge; latch owner, address, write data and func3 into M_* registers; no request -> stay IDLE.
REQ-012 Fixed priority: D over I, except when the starve counter has reached STARVE_LIMIT and I_READ is high, then I wins.
REQ-013 Starve counter: +1 per D grant while I_READ high; cleared on an I grant or when I_READ is low; saturates at STARVE_LIMIT.
REQ-014 GRANT: M_READ/M_WRITE held; an edge sampling M_BUSYWAIT=0 -> RELEASE and capture M_READDATA into owner's READDATA register (reads only).
REQ-015 RELEASE: lasts exactly one cycle; M_READ=M_WRITE=0; then -> IDLE.
REQ-016 Instruction transactions SHALL drive M_FUNC3=3'b010 and M_WRITE=0.
REQ-017 D_READ and D_WRITE both high SHALL be treated as a write.
REQ-018 x_BUSYWAIT SHALL be combinational: high when the x request is high, except in RELEASE with owner=x.
REQ-019 Zero-wait memory: request at edge 0 -> GRANT cycle 1 -> RELEASE cycle 2, x_BUSYWAIT low and x_READDATA valid in cycle 2.
REQ-020 Request dropped during GRANT: transaction SHALL complete; no READDATA update is required to be observed.
REQ-021 I_READDATA/D_READDATA SHALL hold their value until the next completed read for that side.
REQ-022 Requests arriving during GRANT/RELEASE SHALL wait; arbitration occurs only in IDLE.

Reset
REQ-023 RESET low SHALL immediately force IDLE, owner=D, starve counter=0, M_READ=M_WRITE=0, M_ADDRESS=M_WRITEDATA=0, M_FUNC3=0, I_READDATA=D_READDATA=0.
REQ-024 Reset during GRANT SHALL abandon the transaction; after release, arbitration restarts from IDLE.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: round-robin, last-granted side loses a tie; starve counter and STARVE_LIMIT unused.
REQ-026 MEM_ARB_RR_EN undefined: fixed D priority with starvation limit per REQ-012/013.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold state encodings (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10), owner encoding (OWN_I=0, OWN_D=1) and FUNC3_WORD=3'b010.
REQ-028 Sub-module mem_arb_select SHALL contain the grant decision and the starve counter / round-robin pointer.

Verification
REQ-029 Lone I_READ at 0x100, M_BUSYWAIT held 3 cycles, M_READDATA=0x00500093 -> I_READDATA=0x00500093 in RELEASE, I_BUSYWAIT high for 4 cycles.
REQ-030 I_READ and D_READ simultaneously, default build -> D granted first, I granted after D's RELEASE.
REQ-031 D_WRITE continuously with I_READ high, STARVE_LIMIT=4 -> fifth grant goes to I.
REQ-032 D_WRITE 0x200, data 0xDEADBEEF, func3 3'b000 -> M_WRITE=1, M_ADDRESS=0x200, M_WRITEDATA=0xDEADBEEF, M_FUNC3=3'b000 for the whole GRANT.
REQ-033 RESET low mid-GRANT -> M_READ=M_WRITE=0 immediately, state IDLE, both READDATA=0.
REQ-034 MEM_ARB_RR_EN build, both sides requesting continuously -> grants alternate D, I, D, I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  // Side currently owning the shared memory port.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Access size used for every instruction fetch.
  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the memory arbiter.
// Default build: data side has priority, bounded by a starve counter on the instruction side.
// With MEM_ARB_RR_EN defined: round-robin, the last granted side loses a tie.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   arb_en,
  output logic   grant_valid,
  output owner_e grant_owner
);

  assign grant_valid = arb_en & (i_req | d_req);

`ifdef MEM_ARB_RR_EN

  owner_e last_q;

  // Tie goes to whichever side was not granted last.
  always_comb begin
    grant_owner = d_req ? OWN_D : OWN_I;
    if (i_req && d_req) begin
      grant_owner = (last_q == OWN_D) ? OWN_I : OWN_D;
    end
  end

  // Reset to OWN_I so the first tie goes to the data side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (grant_valid) begin
      last_q <= grant_owner;
    end
  end

`else

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CntW-1:0] starve_q;
  logic            starved;

  assign starved = 32'(starve_q) >= STARVE_LIMIT;

  // Data wins unless the instruction side has waited out STARVE_LIMIT data grants.
  always_comb begin
    grant_owner = (d_req && !(i_req && starved)) ? OWN_D : OWN_I;
  end

  // Count data grants taken while a fetch waits; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!i_req) begin
      starve_q <= '0;
    end else if (grant_valid) begin
      if (grant_owner == OWN_I) begin
        starve_q <= '0;
      end else if (!starved) begin
        starve_q <= starve_q + CntW'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one shared memory port.
// Optional round-robin arbitration is selected by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction side
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_readdata,
  output logic        i_busywait,
  // Data side
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [2:0]  d_func3,
  output logic [31:0] d_readdata,
  output logic        d_busywait,
  // Shared memory port
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_address,
  output logic [31:0] m_writedata,
  output logic [2:0]  m_func3,
  input  logic [31:0] m_readdata,
  input  logic        m_busywait
);

  arb_state_e state_q;
  owner_e     owner_q;
  owner_e     grant_owner;
  logic       grant_valid;
  logic       d_req;
  logic       arb_en;

  assign d_req  = d_read | d_write;
  assign arb_en = (state_q == IDLE);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_read),
    .d_req      (d_req),
    .arb_en     (arb_en),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // Stall each requester until its own RELEASE cycle.
  assign i_busywait = i_read & ~((state_q == RELEASE) & (owner_q == OWN_I));
  assign d_busywait = d_req & ~((state_q == RELEASE) & (owner_q == OWN_D));

  // Arbitration FSM with registered memory-port outputs and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      m_func3     <= '0;
      i_readdata  <= '0;
      d_readdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q <= GRANT;
            owner_q <= grant_owner;
            if (grant_owner == OWN_I) begin
              m_read    <= 1'b1;
              m_write   <= 1'b0;
              m_address <= i_address;
              m_func3   <= FUNC3_WORD;
            end else begin
              // Read and write together is treated as a write.
              m_read      <= ~d_write;
              m_write     <= d_write;
              m_address   <= d_address;
              m_writedata <= d_writedata;
              m_func3     <= d_func3;
            end
          end
        end
        GRANT: begin
          if (!m_busywait) begin
            state_q <= RELEASE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (m_read) begin
              if (owner_q == OWN_I) begin
                i_readdata <= m_readdata;
              end else begin
                d_readdata <= m_readdata;
              end
            end
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: word-store memory model with random latency,
// I/D drivers, a grant-order reference model and queue-based response/bus scoreboards.
module tb_mem_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } d_ent_t;

  logic        clk;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [2:0]  d_func3;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_address;
  logic [31:0] m_writedata;
  logic [2:0]  m_func3;
  logic [31:0] m_readdata;
  logic        m_busywait;

  int n_vec;
  int n_miss;

  logic [31:0] i_exp_q[$];
  d_ent_t      d_rsp_q[$];
  d_ent_t      d_bus_q[$];
  logic [31:0] ref_d[16];

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_readdata (i_readdata),
    .i_busywait (i_busywait),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_writedata(d_writedata),
    .d_func3    (d_func3),
    .d_readdata (d_readdata),
    .d_busywait (d_busywait),
    .m_read     (m_read),
    .m_write    (m_write),
    .m_address  (m_address),
    .m_writedata(m_writedata),
    .m_func3    (m_func3),
    .m_readdata (m_readdata),
    .m_busywait (m_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction space (0x100..) is read-only and computed; data space (0x200..) is a word store.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] dinit(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0011_0011;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_d[16];
  logic [15:0] mem_w;
  logic        mem_clr;
  int          wait_cnt;
  int          force_lat;

  always @(posedge clk) begin
    if (mem_clr) mem_w <= '0;
    if (!(m_read || m_write)) begin
      wait_cnt <= (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end else if (m_write && m_address[9]) begin
      mem_d[m_address[5:2]] <= m_writedata;
      mem_w[m_address[5:2]] <= 1'b1;
    end
  end

  assign m_busywait = (m_read || m_write) && (wait_cnt != 0);
  assign m_readdata = m_address[9]
                    ? (mem_w[m_address[5:2]] ? mem_d[m_address[5:2]] : dinit(int'(m_address[5:2])))
                    : imem(m_address);

  // ---------------- grant-order reference ----------------
  logic prev_act, prev_i, prev_d, last_d;
  int   starve;

  always @(negedge clk) begin
    logic act, newg, got_d, want_d;
    act    = m_read | m_write;
    want_d = 1'b0;
    if (!rst_n) begin
      prev_act <= 1'b0;
      prev_i   <= 1'b0;
      prev_d   <= 1'b0;
      last_d   <= 1'b0;
      starve   <= 0;
    end else begin
      newg = act && !prev_act;
      if (newg) begin
        got_d = m_address[9];
        if (prev_i && prev_d) begin
`ifdef MEM_ARB_RR_EN
          want_d = !last_d;
`else
          want_d = !(starve >= int'(STARVE_LIMIT));
`endif
        end else begin
          want_d = prev_d;
        end
        check("grant_side_is_d", {31'b0, got_d}, {31'b0, want_d});
        last_d <= want_d;
      end
      if (!prev_i) starve <= 0;
      else if (newg) starve <= want_d ? ((starve < int'(STARVE_LIMIT)) ? starve + 1 : starve) : 0;
      prev_act <= act;
      prev_i   <= i_read;
      prev_d   <= d_read | d_write;
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    d_ent_t e;
    if (rst_n && (m_read || m_write)) begin
      if (!m_address[9]) begin
        check("i_bus_rd_wr_f3", {27'b0, m_read, m_write, m_func3}, {27'b0, 1'b1, 1'b0, 3'b010});
      end else if (d_bus_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL d_bus_unexpected: got addr %h want no transaction", m_address);
      end else begin
        e = d_bus_q[0];
        check("d_bus_addr", m_address, e.addr);
        check("d_bus_rd_wr_f3", {27'b0, m_read, m_write, m_func3},
              {27'b0, !e.is_write, e.is_write, e.f3});
        if (e.is_write) check("d_bus_wdata", m_writedata, e.data);
        if (!m_busywait) void'(d_bus_q.pop_front());
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    d_ent_t r;
    if (rst_n) begin
      if (i_read && !i_busywait) begin
        if (i_exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL i_rsp_unexpected: got %h want no response", i_readdata);
        end else begin
          check("i_readdata", i_readdata, i_exp_q.pop_front());
        end
      end
      if ((d_read || d_write) && !d_busywait) begin
        if (d_rsp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL d_rsp_unexpected: got %h want no response", d_readdata);
        end else begin
          r = d_rsp_q.pop_front();
          if (!r.is_write) check("d_readdata", d_readdata, r.data);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic i_txn(input logic [31:0] a, output int busy);
    int n;
    busy      = 0;
    n         = 0;
    i_address = a;
    i_read    = 1'b1;
    i_exp_q.push_back(imem(a));
    do begin
      @(negedge clk);
      n++;
      if (m_read && i_busywait && !m_address[9]) busy++;
    end while (i_busywait && n < 200);
    if (i_busywait) begin
      n_vec++;
      n_miss++;
      $display("FAIL i_timeout: got busywait=1 after %0d cycles want 0", n);
    end
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 read+write (acts as write)
  task automatic d_txn(input int kind, input int k, input logic [31:0] wd, input logic [2:0] f3);
    d_ent_t e;
    int     n;
    e.addr      = 32'h200 + 32'(k) * 4;
    e.is_write  = (kind != 0);
    e.f3        = f3;
    d_address   = e.addr;
    d_writedata = wd;
    d_func3     = f3;
    d_read      = (kind != 1);
    d_write     = (kind != 0);
    if (e.is_write) begin
      ref_d[k] = wd;
      e.data   = wd;
    end else begin
      e.data = ref_d[k];
    end
    d_bus_q.push_back(e);
    d_rsp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_busywait && n < 200);
    if (d_busywait) begin
      n_vec++;
      n_miss++;
      $display("FAIL d_timeout: got busywait=1 after %0d cycles want 0", n);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int busy;
    int n;
    n_vec       = 0;
    n_miss      = 0;
    force_lat   = 0;
    mem_clr     = 1'b1;
    rst_n       = 1'b0;
    i_read      = 1'b0;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_address   = '0;
    d_writedata = '0;
    d_func3     = '0;
    for (int k = 0; k < 16; k++) ref_d[k] = dinit(k);

    #12;
    check("rst_m_read", {31'b0, m_read}, 32'd0);
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_m_func3", {29'b0, m_func3}, 32'd0);
    check("rst_i_readdata", i_readdata, 32'd0);
    check("rst_d_readdata", d_readdata, 32'd0);
    check("rst_busywaits", {30'b0, i_busywait, d_busywait}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // Lone fetch with three busy memory cycles: four GRANT cycles with the fetch stalled.
    force_lat = 3;
    i_txn(32'h100, busy);
    i_read = 1'b0;
    check("i_grant_stall_cycles", 32'(busy), 32'd4);

    // Byte write then read-back on the data side.
    force_lat = 1;
    d_txn(1, 0, 32'hDEAD_BEEF, 3'b000);
    d_txn(0, 0, 32'h0, 3'b010);
    d_read = 1'b0;

    // Simultaneous requests.
    force_lat = 0;
    fork
      begin i_txn(32'h108, busy); i_read = 1'b0; end
      begin d_txn(0, 2, 32'h0, 3'b010); d_read = 1'b0; d_write = 1'b0; end
    join

    // Back-to-back data writes with a fetch waiting.
    fork
      begin i_txn(32'h10C, busy); i_read = 1'b0; end
      begin
        for (int j = 0; j < 6; j++) d_txn(1, 3 + j, $urandom, 3'b010);
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    join

    // Random traffic from both sides.
    force_lat = -1;
    fork
      begin
        for (int j = 0; j < 60; j++) begin
          int gap;
          i_txn(32'h100 + 32'($urandom_range(0, 15)) * 4, busy);
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            i_read = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        i_read = 1'b0;
      end
      begin
        for (int j = 0; j < 60; j++) begin
          int gap;
          d_txn($urandom_range(0, 2), $urandom_range(0, 15), $urandom, 3'($urandom_range(0, 7)));
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    join

    // Reset in the middle of a long data read.
    repeat (2) @(posedge clk);
    #1;
    force_lat = 10;
    d_address = 32'h204;
    d_func3   = 3'b010;
    d_read    = 1'b1;
    d_write   = 1'b0;
    d_bus_q.push_back('{is_write: 1'b0, addr: 32'h204, data: 32'h0, f3: 3'b010});
    n = 0;
    while (!m_read && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_reset_grant_seen", {31'b0, m_read}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_m_rd_wr", {30'b0, m_read, m_write}, 32'd0);
    check("mid_reset_i_readdata", i_readdata, 32'd0);
    check("mid_reset_d_readdata", d_readdata, 32'd0);
    d_read = 1'b0;
    d_bus_q.delete();
    d_rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", {30'b0, m_read, m_write}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
